core_fetch: RTL

Instruction fetch unit for the RV32IM core. It holds the program counter and issues single-word reads on the instruction-memory bus. Each returned word is presented to the execute stage as `instr` with its `instr_pc` under a valid/ready handshake. It applies jump/branch redirects from the execute stage and discards any in-flight fetch they make stale. The design is non-pipelined, with at most one outstanding bus read.

---
 rtl/core_fetch_if.sv | 31 +++
 rtl/core_fetch.sv | 106 ++++++++++
 2 files changed

// File: rtl/core_fetch_if.sv
// Instruction-fetch bundle: instruction-memory read bus, fetched-instruction
// handshake toward execute, and the redirect request coming back from execute.
interface core_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output instr_valid, instr, instr_pc, instr_fault,
    input  instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  instr_valid, instr, instr_pc, instr_fault,
    output instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/core_fetch.sv
// Non-pipelined instruction fetch: one outstanding imem read, redirect handling
// with stale-response draining, and a valid/ready hand-off to execute.
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  core_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_fault_q;

  logic        pc_redir;
  logic        pc_inc;
  logic        capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A granted read must always see its response, so a redirect after grant
  // parks in DROP until the stale rvalid arrives (unless it arrives right now).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (bus.imem_gnt) begin
          state_nxt = bus.redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          state_nxt = bus.imem_rvalid ? REQ : DROP;
        end else if (bus.imem_rvalid) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect || bus.instr_ready) begin
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_redir = bus.redirect && (state != IDLE);
    pc_inc   = (state == HOLD) && !bus.redirect && bus.instr_ready;
    capture  = (state == WAIT) && !bus.redirect && bus.imem_rvalid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC & ALIGN_MASK;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_fault_q <= 1'b0;
    end else begin
      if (pc_redir) begin
        pc <= bus.redirect_pc & ALIGN_MASK;
      end else if (pc_inc) begin
        pc <= pc + 32'd4;
      end
      if (capture) begin
        instr_q       <= bus.imem_err ? 32'h0 : bus.imem_rdata;
        instr_pc_q    <= pc;
        instr_fault_q <= bus.imem_err;
      end
    end
  end

  // Outputs depend only on registered state, never on ready/redirect.
  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = pc & ALIGN_MASK;
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_fault = instr_fault_q;

endmodule
